// File: rtl/dc_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : dc_issue_stage
// Purpose  : Directory-cache stage-1 issue arbiter. Picks one of three message
//            sources (replacement, response, request) each cycle, registers the
//            winning message into the dc1_message_* outputs and reads the
//            indexed set's per-way valid/state/tag alongside it.
//
// Ports    : clk, reset              - clock, asynchronous active-high reset
//            rep_* / rsp_* / req_*   - per-source valid/ready handshake and
//                                      type/address/data/source payloads
//            tshr_full               - no free TSHR entry; requests stall
//            dc2_pending[_address]   - stage-2 in-flight address (set hazard)
//            dc3_update_cache_*      - tag/state/valid write port from stage 3
//            dc1_message_*           - registered issued message
//            dc1_message_cache_*     - per-way valid/state/tag of issued set
//
// Revision : 1.0 - initial release
// ============================================================================
module dc_issue_stage #(
    parameter int STARVE_LIMIT = 8,
    parameter int TYPE_W       = 4,
    parameter int DATA_W       = 64,
    parameter int SOURCE_W     = 4,
    parameter int STATE_W      = 2,
    parameter int TAG_W        = 8,
    parameter int SET_W        = 4,
    parameter int OFFSET_W     = 2,
    parameter int WAYS         = 4,
    parameter int WAY_IDX_W    = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int ADDR_W       = TAG_W + SET_W + OFFSET_W
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     rep_valid,
    output logic                     rep_ready,
    input  logic [TYPE_W-1:0]        rep_type,
    input  logic [ADDR_W-1:0]        rep_address,
    input  logic [DATA_W-1:0]        rep_data,
    input  logic [SOURCE_W-1:0]      rep_source,

    input  logic                     rsp_valid,
    output logic                     rsp_ready,
    input  logic [TYPE_W-1:0]        rsp_type,
    input  logic [ADDR_W-1:0]        rsp_address,
    input  logic [DATA_W-1:0]        rsp_data,
    input  logic [SOURCE_W-1:0]      rsp_source,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TYPE_W-1:0]        req_type,
    input  logic [ADDR_W-1:0]        req_address,
    input  logic [DATA_W-1:0]        req_data,
    input  logic [SOURCE_W-1:0]      req_source,

    input  logic                     tshr_full,
    input  logic                     dc2_pending,
    input  logic [ADDR_W-1:0]        dc2_pending_address,

    input  logic                     dc3_update_cache_enable,
    input  logic [SET_W-1:0]         dc3_update_cache_set,
    input  logic [WAY_IDX_W-1:0]     dc3_update_cache_way,
    input  logic [TAG_W-1:0]         dc3_update_cache_tag,
    input  logic [STATE_W-1:0]       dc3_update_cache_state,
    input  logic                     dc3_update_cache_valid,

    output logic                     dc1_message_valid,
    output logic [TYPE_W-1:0]        dc1_message_type,
    output logic [ADDR_W-1:0]        dc1_message_address,
    output logic [DATA_W-1:0]        dc1_message_data,
    output logic [SOURCE_W-1:0]      dc1_message_source,
    output logic [WAYS-1:0]          dc1_message_cache_valid,
    output logic [WAYS*STATE_W-1:0]  dc1_message_cache_state,
    output logic [WAYS*TAG_W-1:0]    dc1_message_cache_tag
);

    localparam int         c_sets         = 1 << SET_W;
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_starve_max   = 4'd15;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]                      starve_cnt_q, starve_cnt_d;
    logic                            dc1_valid_q, dc1_valid_d;
    logic [TYPE_W-1:0]               dc1_type_q, dc1_type_d;
    logic [ADDR_W-1:0]               dc1_address_q, dc1_address_d;
    logic [DATA_W-1:0]               dc1_data_q, dc1_data_d;
    logic [SOURCE_W-1:0]             dc1_source_q, dc1_source_d;
    logic [WAYS-1:0]                 cache_valid_q, cache_valid_d;
    logic [WAYS*STATE_W-1:0]         cache_state_q, cache_state_d;
    logic [WAYS*TAG_W-1:0]           cache_tag_q, cache_tag_d;

    // Valid bits live in resettable flops; tag/state are plain storage.
    logic [c_sets-1:0][WAYS-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]                tag_mem   [c_sets][WAYS];
    logic [STATE_W-1:0]              state_mem [c_sets][WAYS];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [SET_W-1:0] w_req_set;
    logic [SET_W-1:0] w_dc2_set;
    logic [SET_W-1:0] w_dc1_set;
    logic [SET_W-1:0] w_grant_set;
    logic             w_req_hazard;
    logic             w_req_ok;
    logic             w_starved;
    logic             w_grant_rep;
    logic             w_grant_rsp;
    logic             w_grant_req;
    logic             w_transfer;
    logic             w_unused_dc2;

    assign w_req_set = req_address[OFFSET_W +: SET_W];
    assign w_dc2_set = dc2_pending_address[OFFSET_W +: SET_W];
    assign w_dc1_set = dc1_address_q[OFFSET_W +: SET_W];

    // Only the set index of the stage-2 address matters for hazards.
    assign w_unused_dc2 = ^{dc2_pending_address[ADDR_W-1:OFFSET_W+SET_W],
                            dc2_pending_address[OFFSET_W-1:0]};

    // A request to a set already in flight in dc1 or dc2 must wait so the
    // directory never sees two overlapping transactions on one set.
    assign w_req_hazard = (dc2_pending && (w_dc2_set == w_req_set)) ||
                          (dc1_valid_q && (w_dc1_set == w_req_set));
    assign w_req_ok     = req_valid && !tshr_full && !w_req_hazard;
    assign w_starved    = (starve_cnt_q >= c_starve_limit);

    always_comb begin : arbitration
        w_grant_rep = 1'b0;
        w_grant_rsp = 1'b0;
        w_grant_req = 1'b0;
        // All readies stay low while reset is held.
        if (!reset) begin
            if (rep_valid) begin
                w_grant_rep = 1'b1;
            end else if (w_starved && w_req_ok) begin
                w_grant_req = 1'b1;
            end else if (rsp_valid) begin
                w_grant_rsp = 1'b1;
            end else if (w_req_ok) begin
                w_grant_req = 1'b1;
            end
        end
    end

    // A grant is only ever given to a valid source, so grant == transfer.
    assign rep_ready  = w_grant_rep;
    assign rsp_ready  = w_grant_rsp;
    assign req_ready  = w_grant_req;
    assign w_transfer = w_grant_rep || w_grant_rsp || w_grant_req;

    always_comb begin : starve_update
        starve_cnt_d = starve_cnt_q;
        if (!req_valid || w_grant_req) begin
            starve_cnt_d = 4'd0;
        end else if (w_req_ok && (w_grant_rep || w_grant_rsp)) begin
            // Blocked requests hold the count; only real lost arbitration ages it.
            if (starve_cnt_q != c_starve_max) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin : payload_select
        dc1_valid_d   = w_transfer;
        dc1_type_d    = dc1_type_q;
        dc1_address_d = dc1_address_q;
        dc1_data_d    = dc1_data_q;
        dc1_source_d  = dc1_source_q;
        if (w_grant_rep) begin
            dc1_type_d    = rep_type;
            dc1_address_d = rep_address;
            dc1_data_d    = rep_data;
            dc1_source_d  = rep_source;
        end else if (w_grant_rsp) begin
            dc1_type_d    = rsp_type;
            dc1_address_d = rsp_address;
            dc1_data_d    = rsp_data;
            dc1_source_d  = rsp_source;
        end else if (w_grant_req) begin
            dc1_type_d    = req_type;
            dc1_address_d = req_address;
            dc1_data_d    = req_data;
            dc1_source_d  = req_source;
        end
    end

    assign w_grant_set = dc1_address_d[OFFSET_W +: SET_W];

    // Set read for the granted message. A same-cycle stage-3 write to the
    // set being read is forwarded for the written way only.
    always_comb begin : cache_read
        cache_valid_d = cache_valid_q;
        cache_state_d = cache_state_q;
        cache_tag_d   = cache_tag_q;
        if (w_transfer) begin
            for (int w = 0; w < WAYS; w++) begin
                if (dc3_update_cache_enable &&
                    (dc3_update_cache_set == w_grant_set) &&
                    (dc3_update_cache_way == WAY_IDX_W'(w))) begin
                    cache_valid_d[w]                   = dc3_update_cache_valid;
                    cache_state_d[w*STATE_W +: STATE_W] = dc3_update_cache_state;
                    cache_tag_d[w*TAG_W +: TAG_W]       = dc3_update_cache_tag;
                end else begin
                    cache_valid_d[w]                   = valid_q[w_grant_set][w];
                    cache_state_d[w*STATE_W +: STATE_W] = state_mem[w_grant_set][w];
                    cache_tag_d[w*TAG_W +: TAG_W]       = tag_mem[w_grant_set][w];
                end
            end
        end
    end

    always_comb begin : valid_update
        valid_d = valid_q;
        if (dc3_update_cache_enable) begin
            valid_d[dc3_update_cache_set][dc3_update_cache_way] = dc3_update_cache_valid;
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin : ctrl_regs
        if (reset) begin
            dc1_valid_q  <= 1'b0;
            starve_cnt_q <= 4'd0;
            valid_q      <= '0;
        end else begin
            dc1_valid_q  <= dc1_valid_d;
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
        end
    end

    // Payload and read-data registers hold their value without a transfer,
    // so they need no reset.
    always_ff @(posedge clk) begin : data_regs
        dc1_type_q    <= dc1_type_d;
        dc1_address_q <= dc1_address_d;
        dc1_data_q    <= dc1_data_d;
        dc1_source_q  <= dc1_source_d;
        cache_valid_q <= cache_valid_d;
        cache_state_q <= cache_state_d;
        cache_tag_q   <= cache_tag_d;
    end

    always_ff @(posedge clk) begin : tag_state_write
        if (dc3_update_cache_enable) begin
            tag_mem[dc3_update_cache_set][dc3_update_cache_way]   <= dc3_update_cache_tag;
            state_mem[dc3_update_cache_set][dc3_update_cache_way] <= dc3_update_cache_state;
        end
    end

    assign dc1_message_valid       = dc1_valid_q;
    assign dc1_message_type        = dc1_type_q;
    assign dc1_message_address     = dc1_address_q;
    assign dc1_message_data        = dc1_data_q;
    assign dc1_message_source      = dc1_source_q;
    assign dc1_message_cache_valid = cache_valid_q;
    assign dc1_message_cache_state = cache_state_q;
    assign dc1_message_cache_tag   = cache_tag_q;

endmodule
`default_nettype wire
